// File: rtl/window_stack_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_stack_regfile                                                        |
// | Windowed register file with circular storage and spill/fill to a stack.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module window_stack_regfile #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int STRIDE  = 2,
  parameter int NUM_WIN = 4,
  parameter int DEPTH_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          ReadReg1,
  input  logic [ADDR_W-1:0]          ReadReg2,
  output logic [DATA_W-1:0]          ReadData1,
  output logic [DATA_W-1:0]          ReadData2,
  input  logic                       WriteDataEnable,
  input  logic [ADDR_W-1:0]          WriteReg,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic                       call,
  input  logic                       ret,
  output logic                       busy,
  output logic [$clog2(NUM_WIN)-1:0] cwp,
  output logic [DEPTH_W-1:0]         depth,
  output logic                       spill_valid,
  input  logic                       spill_ready,
  output logic [DATA_W-1:0]          spill_data,
  input  logic                       fill_valid,
  output logic                       fill_ready,
  input  logic [DATA_W-1:0]          fill_data,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int c_P      = NUM_WIN * STRIDE;
  localparam int c_CWP_W  = $clog2(NUM_WIN);
  localparam int c_PHYS_W = $clog2(c_P);
  localparam int c_SUM_W  = $clog2(2 * c_P) + 1;
  localparam int c_BEAT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int c_WRAP_W = c_CWP_W + 2;

  localparam logic [c_CWP_W-1:0]  c_RES_MAX   = c_CWP_W'(NUM_WIN - 1);
  localparam logic [c_CWP_W-1:0]  c_RES_ONE   = c_CWP_W'(1);
  localparam logic [DEPTH_W-1:0]  c_DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(STRIDE - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SPILL = 2'd1;
  localparam logic [1:0] c_FILL  = 2'd2;

  logic [DATA_W-1:0]   r_regs [c_P];
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_CWP_W-1:0]  r_res;
  logic [c_CWP_W-1:0]  r_xwin;
  logic [c_BEAT_W-1:0] r_beat;

  // Sum is always below 2*P, so one conditional subtract gives the modulo.
  function automatic logic [c_PHYS_W-1:0] f_phys(input logic [c_CWP_W-1:0] win,
                                                 input logic [c_SUM_W-1:0] off);
    logic [c_SUM_W-1:0] s;
    s = c_SUM_W'(win) * c_SUM_W'(STRIDE) + off;
    if (s >= c_SUM_W'(c_P)) s = s - c_SUM_W'(c_P);
    return c_PHYS_W'(s);
  endfunction

  logic [c_CWP_W-1:0]  w_cwp_inc;
  logic [c_CWP_W-1:0]  w_cwp_dec;
  logic [c_WRAP_W-1:0] w_fwd2;
  logic [c_CWP_W-1:0]  w_oldest;

  assign w_cwp_inc = (cwp == c_RES_MAX) ? '0 : cwp + c_CWP_W'(1);
  assign w_cwp_dec = (cwp == '0) ? c_RES_MAX : cwp - c_CWP_W'(1);
  // Spilling only happens with res = NUM_WIN-1, so oldest = cwp - res + 1 = cwp + 2.
  assign w_fwd2    = c_WRAP_W'(cwp) + c_WRAP_W'(2);
  assign w_oldest  = (w_fwd2 >= c_WRAP_W'(NUM_WIN)) ? c_CWP_W'(w_fwd2 - c_WRAP_W'(NUM_WIN))
                                                    : c_CWP_W'(w_fwd2);

  logic w_call_go;
  logic w_ret_go;
  logic w_spill_req;
  logic w_fill_req;

  assign w_call_go   = (r_state == c_IDLE) && call && !ret && (depth != c_DEPTH_MAX);
  assign w_ret_go    = (r_state == c_IDLE) && ret && !call && (depth != '0);
  assign w_spill_req = w_call_go && (r_res == c_RES_MAX);
  assign w_fill_req  = w_ret_go && (r_res == c_RES_ONE);

  logic [c_PHYS_W-1:0] w_xfer_phys;
  assign w_xfer_phys = f_phys(r_xwin, c_SUM_W'(r_beat));

  // Single write port shared by normal writes and fill beats; reads bypass from it.
  logic                w_wr_en;
  logic [c_PHYS_W-1:0] w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

  assign w_wr_en   = ((r_state == c_IDLE) && WriteDataEnable) ||
                     ((r_state == c_FILL) && fill_valid);
  assign w_wr_addr = (r_state == c_FILL) ? w_xfer_phys : f_phys(cwp, c_SUM_W'(WriteReg));
  assign w_wr_data = (r_state == c_FILL) ? fill_data : WriteData;

  logic [c_PHYS_W-1:0] w_rd1_phys;
  logic [c_PHYS_W-1:0] w_rd2_phys;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;

  assign w_rd1_phys = f_phys(cwp, c_SUM_W'(ReadReg1));
  assign w_rd2_phys = f_phys(cwp, c_SUM_W'(ReadReg2));
  assign w_rd1 = (w_wr_en && (w_wr_addr == w_rd1_phys)) ? w_wr_data : r_regs[w_rd1_phys];
  assign w_rd2 = (w_wr_en && (w_wr_addr == w_rd2_phys)) ? w_wr_data : r_regs[w_rd2_phys];

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_spill_req)     w_state_nxt = c_SPILL;
        else if (w_fill_req) w_state_nxt = c_FILL;
      end
      c_SPILL: if (spill_ready && (r_beat == c_BEAT_LAST)) w_state_nxt = c_IDLE;
      c_FILL:  if (fill_valid && (r_beat == '0))           w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != c_IDLE);
    spill_valid = (r_state == c_SPILL);
    fill_ready  = (r_state == c_FILL);
    spill_data  = (r_state == c_SPILL) ? r_regs[w_xfer_phys] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cwp       <= '0;
      r_res     <= c_RES_ONE;
      depth     <= '0;
      r_xwin    <= '0;
      r_beat    <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      ReadData1 <= '0;
      ReadData2 <= '0;
      for (int i = 0; i < c_P; i++) r_regs[i] <= '0;
    end else begin
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      ReadData1 <= w_rd1;
      ReadData2 <= w_rd2;
      if (w_wr_en) r_regs[w_wr_addr] <= w_wr_data;
      case (r_state)
        c_IDLE: begin
          if (call && !ret) begin
            if (depth == c_DEPTH_MAX) begin
              err_ovf <= 1'b1;
            end else if (r_res != c_RES_MAX) begin
              cwp   <= w_cwp_inc;
              r_res <= r_res + c_CWP_W'(1);
              depth <= depth + DEPTH_W'(1);
            end else begin
              r_xwin <= w_oldest;
              r_beat <= '0;
            end
          end else if (ret && !call) begin
            if (depth == '0) begin
              err_unf <= 1'b1;
            end else if (r_res != c_RES_ONE) begin
              cwp   <= w_cwp_dec;
              r_res <= r_res - c_CWP_W'(1);
              depth <= depth - DEPTH_W'(1);
            end else begin
              r_xwin <= w_cwp_dec;
              r_beat <= c_BEAT_LAST;
            end
          end
        end
        c_SPILL: begin
          if (spill_ready) begin
            if (r_beat == c_BEAT_LAST) begin
              cwp   <= w_cwp_inc;
              depth <= depth + DEPTH_W'(1);
            end else begin
              r_beat <= r_beat + c_BEAT_W'(1);
            end
          end
        end
        c_FILL: begin
          if (fill_valid) begin
            if (r_beat == '0) begin
              cwp   <= w_cwp_dec;
              depth <= depth - DEPTH_W'(1);
            end else begin
              r_beat <= r_beat - c_BEAT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_stack_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_window_stack_regfile                                                     |
// | Directed bench for the windowed register file with spill/fill.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_window_stack_regfile;

  logic        clk;
  logic        rst;
  logic [1:0]  ReadReg1, ReadReg2;
  logic [15:0] ReadData1, ReadData2;
  logic        WriteDataEnable;
  logic [1:0]  WriteReg;
  logic [15:0] WriteData;
  logic        call, ret;
  logic        busy;
  logic [1:0]  cwp;
  logic [7:0]  depth;
  logic        spill_valid, spill_ready;
  logic [15:0] spill_data;
  logic        fill_valid, fill_ready;
  logic [15:0] fill_data;
  logic        err_ovf, err_unf;

  int total = 0;
  int bad   = 0;

  window_stack_regfile dut (
    .clk(clk), .rst(rst),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteDataEnable(WriteDataEnable), .WriteReg(WriteReg), .WriteData(WriteData),
    .call(call), .ret(ret), .busy(busy), .cwp(cwp), .depth(depth),
    .spill_valid(spill_valid), .spill_ready(spill_ready), .spill_data(spill_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; call = 1'b0; ret = 1'b0; WriteDataEnable = 1'b0;
    WriteReg = 2'd0; WriteData = 16'h0; ReadReg1 = 2'd0; ReadReg2 = 2'd0;
    spill_ready = 1'b1; fill_valid = 1'b0; fill_data = 16'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (cwp !== 2'd0) begin bad++; $display("FAIL rst_cwp got=%0d want=0", cwp); end
    total++; if (depth !== 8'd0) begin bad++; $display("FAIL rst_depth got=%0d want=0", depth); end
    total++; if ({busy, spill_valid, fill_ready, err_ovf, err_unf} !== 5'b0) begin
      bad++; $display("FAIL rst_flags got=%b want=00000", {busy, spill_valid, fill_ready, err_ovf, err_unf});
    end
    total++; if (spill_data !== 16'h0) begin bad++; $display("FAIL rst_spill_data got=%h want=0000", spill_data); end
    for (int i = 0; i < 4; i++) begin
      ReadReg1 = 2'(i); ReadReg2 = 2'(3 - i);
      tick();
      total++; if (ReadData1 !== 16'h0 || ReadData2 !== 16'h0) begin
        bad++; $display("FAIL rst_read%0d got=%h/%h want=0000/0000", i, ReadData1, ReadData2);
      end
    end
  endtask

  task automatic test_write_call();
    WriteDataEnable = 1'b1; WriteReg = 2'd2; WriteData = 16'hAAAA;
    tick();
    WriteDataEnable = 1'b0; call = 1'b1; ReadReg1 = 2'd2;
    tick();
    call = 1'b0;
    total++; if (ReadData1 !== 16'hAAAA) begin bad++; $display("FAIL call_cycle_read got=%h want=aaaa", ReadData1); end
    total++; if (cwp !== 2'd1 || depth !== 8'd1) begin
      bad++; $display("FAIL call_ptr got=%0d/%0d want=1/1", cwp, depth);
    end
    ReadReg1 = 2'd0;
    tick();
    total++; if (ReadData1 !== 16'hAAAA) begin bad++; $display("FAIL overlap_read got=%h want=aaaa", ReadData1); end
    ReadReg1 = 2'd2;
    tick();
    total++; if (ReadData1 !== 16'h0000) begin bad++; $display("FAIL new_win_idx2 got=%h want=0000", ReadData1); end
  endtask

  task automatic test_bypass();
    WriteDataEnable = 1'b1; WriteReg = 2'd1; WriteData = 16'h5555;
    ReadReg2 = 2'd1; ReadReg1 = 2'd0;
    tick();
    WriteDataEnable = 1'b0;
    total++; if (ReadData2 !== 16'h5555) begin bad++; $display("FAIL bypass got=%h want=5555", ReadData2); end
    total++; if (ReadData1 !== 16'hAAAA) begin bad++; $display("FAIL bypass_other got=%h want=aaaa", ReadData1); end
    ret = 1'b1;
    tick();
    ret = 1'b0; ReadReg1 = 2'd3;
    total++; if (cwp !== 2'd0 || depth !== 8'd0) begin
      bad++; $display("FAIL ret_ptr got=%0d/%0d want=0/0", cwp, depth);
    end
    tick();
    total++; if (ReadData1 !== 16'h5555) begin bad++; $display("FAIL alias_back got=%h want=5555", ReadData1); end
  endtask

  task automatic test_spill();
    apply_reset();
    WriteDataEnable = 1'b1; WriteReg = 2'd0; WriteData = 16'h0001;
    tick();
    WriteReg = 2'd1; WriteData = 16'h0002;
    tick();
    WriteDataEnable = 1'b0; call = 1'b1;
    tick();
    total++; if (cwp !== 2'd1 || busy !== 1'b0) begin bad++; $display("FAIL sp_call1 got=%0d/%b want=1/0", cwp, busy); end
    tick();
    total++; if (cwp !== 2'd2 || depth !== 8'd2) begin bad++; $display("FAIL sp_call2 got=%0d/%0d want=2/2", cwp, depth); end
    spill_ready = 1'b0;
    tick();
    total++; if (busy !== 1'b1 || spill_valid !== 1'b1 || spill_data !== 16'h0001) begin
      bad++; $display("FAIL sp_stall1 got=%b/%b/%h want=1/1/0001", busy, spill_valid, spill_data);
    end
    tick();
    call = 1'b0;
    total++; if (busy !== 1'b1 || spill_data !== 16'h0001 || cwp !== 2'd2) begin
      bad++; $display("FAIL sp_stall2 got=%b/%h/%0d want=1/0001/2", busy, spill_data, cwp);
    end
    spill_ready = 1'b1;
    tick();
    total++; if (busy !== 1'b1 || spill_data !== 16'h0002) begin
      bad++; $display("FAIL sp_beat1 got=%b/%h want=1/0002", busy, spill_data);
    end
    tick();
    total++; if (busy !== 1'b0 || spill_valid !== 1'b0 || cwp !== 2'd3 || depth !== 8'd3) begin
      bad++; $display("FAIL sp_done got=%b/%b/%0d/%0d want=0/0/3/3", busy, spill_valid, cwp, depth);
    end
    WriteDataEnable = 1'b1; WriteReg = 2'd2; WriteData = 16'hDEAD;
    tick();
    WriteReg = 2'd3; WriteData = 16'hBEEF; ReadReg1 = 2'd2;
    tick();
    WriteDataEnable = 1'b0;
    total++; if (ReadData1 !== 16'hDEAD) begin bad++; $display("FAIL wrap_write got=%h want=dead", ReadData1); end
  endtask

  task automatic test_fill();
    ret = 1'b1;
    tick();
    total++; if (cwp !== 2'd2 || depth !== 8'd2) begin bad++; $display("FAIL fl_ret1 got=%0d/%0d want=2/2", cwp, depth); end
    tick();
    total++; if (cwp !== 2'd1 || busy !== 1'b0) begin bad++; $display("FAIL fl_ret2 got=%0d/%b want=1/0", cwp, busy); end
    tick();
    ret = 1'b0;
    total++; if (busy !== 1'b1 || fill_ready !== 1'b1) begin
      bad++; $display("FAIL fl_enter got=%b/%b want=1/1", busy, fill_ready);
    end
    fill_valid = 1'b1; fill_data = 16'h0002;
    tick();
    total++; if (busy !== 1'b1 || cwp !== 2'd1) begin bad++; $display("FAIL fl_beat1 got=%b/%0d want=1/1", busy, cwp); end
    fill_data = 16'h0001;
    tick();
    fill_valid = 1'b0;
    total++; if (busy !== 1'b0 || fill_ready !== 1'b0 || cwp !== 2'd0 || depth !== 8'd0) begin
      bad++; $display("FAIL fl_done got=%b/%b/%0d/%0d want=0/0/0/0", busy, fill_ready, cwp, depth);
    end
    ReadReg1 = 2'd0; ReadReg2 = 2'd1;
    tick();
    total++; if (ReadData1 !== 16'h0001 || ReadData2 !== 16'h0002) begin
      bad++; $display("FAIL fl_restore got=%h/%h want=0001/0002", ReadData1, ReadData2);
    end
  endtask

  task automatic test_errors();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    total++; if (err_unf !== 1'b1 || cwp !== 2'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL unf_pulse got=%b/%0d/%b want=1/0/0", err_unf, cwp, busy);
    end
    tick();
    total++; if (err_unf !== 1'b0) begin bad++; $display("FAIL unf_width got=%b want=0", err_unf); end
    call = 1'b1; ret = 1'b1;
    tick();
    call = 1'b0; ret = 1'b0;
    total++; if (cwp !== 2'd0 || depth !== 8'd0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
      bad++; $display("FAIL call_ret got=%0d/%0d/%b/%b want=0/0/0/0", cwp, depth, err_ovf, err_unf);
    end
  endtask

  task automatic test_overflow();
    int n;
    int timeouts;
    timeouts = 0;
    spill_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      call = 1'b1;
      tick();
      call = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 20) begin tick(); n++; end
      if (n >= 20) timeouts++;
    end
    total++; if (timeouts != 0) begin bad++; $display("FAIL ovf_timeout got=%0d want=0", timeouts); end
    total++; if (depth !== 8'd255 || cwp !== 2'd3) begin
      bad++; $display("FAIL ovf_depth got=%0d/%0d want=255/3", depth, cwp);
    end
    call = 1'b1;
    tick();
    call = 1'b0;
    total++; if (err_ovf !== 1'b1 || busy !== 1'b0 || depth !== 8'd255) begin
      bad++; $display("FAIL ovf_pulse got=%b/%b/%0d want=1/0/255", err_ovf, busy, depth);
    end
    tick();
    total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL ovf_width got=%b want=0", err_ovf); end
  endtask

  task automatic test_rst_spill();
    apply_reset();
    call = 1'b1;
    tick(); tick();
    spill_ready = 1'b0;
    tick();
    call = 1'b0;
    total++; if (spill_valid !== 1'b1) begin bad++; $display("FAIL rs_enter got=%b want=1", spill_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (spill_valid !== 1'b0 || busy !== 1'b0 || cwp !== 2'd0 || depth !== 8'd0 || spill_data !== 16'h0) begin
      bad++; $display("FAIL rs_abort got=%b/%b/%0d/%0d/%h want=0/0/0/0/0000", spill_valid, busy, cwp, depth, spill_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_call();
    test_bypass();
    test_spill();
    test_fill();
    test_errors();
    test_overflow();
    test_rst_spill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
